outport_scheduler: RTL



---
 rtl/chiplet_types_pkg.sv | 14 +
 rtl/outport_scheduler_rr_picker.sv | 27 ++
 rtl/outport_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared types and width helpers for the crossbar output-port scheduler.
package chiplet_types_pkg;

   typedef enum logic {IDLE, LOCKED} sched_state_t;

   function automatic int unsigned vc_width(int unsigned num_vcs);
      return (num_vcs > 1) ? $clog2(num_vcs) : 1;
   endfunction

   function automatic int unsigned credit_width(int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/outport_scheduler_rr_picker.sv
// Combinational round-robin priority encoder: first set bit at or after ptr, wrapping.
module rr_picker #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < int'(N); k++) begin
         cand = IDX_W'((int'(ptr) + k) % int'(N));
         if (!found && eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/outport_scheduler.sv
// Wormhole output-port scheduler with per-VC downstream credit tracking.
// Optional lock watchdog enabled by defining OUTPORT_SCHED_TIMEOUT_EN.
module outport_scheduler
   import chiplet_types_pkg::*;
#(
   parameter int unsigned NUM_IN         = 8,
   parameter int unsigned NUM_VCS        = 2,
   parameter int unsigned BUFFER_SIZE    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned VC_W  = vc_width(NUM_VCS),
   localparam int unsigned CW    = credit_width(BUFFER_SIZE),
   localparam int unsigned IDX_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NUM_IN-1:0]       req,
   input  logic [NUM_IN*VC_W-1:0]  req_vc,
   input  logic [NUM_IN-1:0]       req_last,
   input  logic [NUM_VCS-1:0]      credit_granted,
   output logic [NUM_IN-1:0]       pop,
   output logic [IDX_W-1:0]        sel,
   output logic                    out_valid,
   output logic [VC_W-1:0]         out_vc,
   output logic [NUM_VCS*CW-1:0]   credits,
   output logic                    busy,
   output logic                    credit_err,
   output logic                    timeout_err
);

   sched_state_t     state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [VC_W-1:0]  owner_vc_q, owner_vc_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] next_ptr;

   logic [CW-1:0]    credit_q [NUM_VCS];
   logic [CW-1:0]    credit_d [NUM_VCS];
   logic             credit_err_q, credit_err_d;
   logic [NUM_VCS-1:0] credit_ok;

   logic [VC_W-1:0]  vc_of [NUM_IN];
   logic [NUM_IN-1:0] eligible;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             tail_pop;

   always_comb begin
      for (int v = 0; v < int'(NUM_VCS); v++) begin
         credit_ok[v]             = (credit_q[v] != '0);
         credits[v*CW +: CW]      = credit_q[v];
      end
   end

   // A buffer whose VC field names a non-existent VC is never eligible.
   always_comb begin
      for (int i = 0; i < int'(NUM_IN); i++) begin
         vc_of[i]    = req_vc[i*VC_W +: VC_W];
         eligible[i] = req[i] && (int'(vc_of[i]) < int'(NUM_VCS)) && credit_ok[vc_of[i]];
      end
   end

   rr_picker #(
      .N     (NUM_IN),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .eligible (eligible),
      .ptr      (ptr_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   assign next_ptr = IDX_W'((int'(owner_q) + 1) % int'(NUM_IN));
   assign tail_pop = out_valid && req_last[owner_q];

`ifdef OUTPORT_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_q;
   logic            timeout_hit;

   assign timeout_hit = (state_q == LOCKED) && !out_valid &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == LOCKED && !out_valid && !timeout_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end else begin
            to_cnt_q <= '0;
         end
         if (timeout_hit) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_err        = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         owner_vc_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         owner_vc_q <= owner_vc_d;
         ptr_q      <= ptr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      owner_vc_d = owner_vc_q;
      ptr_d      = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = LOCKED;
               owner_d    = pick_idx;
               owner_vc_d = vc_of[pick_idx];
            end
         end
         LOCKED: begin
            if (tail_pop) begin
               state_d = IDLE;
               ptr_d   = next_ptr;
            end
`ifdef OUTPORT_SCHED_TIMEOUT_EN
            if (timeout_hit) begin
               state_d = IDLE;
               ptr_d   = next_ptr;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: the pop is combinational on the owner's request and credit.
   always_comb begin
      pop = '0;
      if (state_q == LOCKED && req[owner_q] && credit_ok[owner_vc_q]) begin
         pop[owner_q] = 1'b1;
      end
      out_valid = |pop;
      sel       = owner_q;
      out_vc    = owner_vc_q;
      busy      = (state_q == LOCKED);
   end

   always_comb begin
      credit_err_d = credit_err_q;
      for (int v = 0; v < int'(NUM_VCS); v++) begin
         credit_d[v] = credit_q[v];
         if (credit_granted[v] && !(out_valid && int'(out_vc) == v)) begin
            if (credit_q[v] == CW'(BUFFER_SIZE)) begin
               credit_err_d = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] + 1'b1;
            end
         end else if (!credit_granted[v] && out_valid && int'(out_vc) == v) begin
            credit_d[v] = credit_q[v] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int v = 0; v < int'(NUM_VCS); v++) begin
            credit_q[v] <= CW'(BUFFER_SIZE);
         end
         credit_err_q <= 1'b0;
      end else begin
         for (int v = 0; v < int'(NUM_VCS); v++) begin
            credit_q[v] <= credit_d[v];
         end
         credit_err_q <= credit_err_d;
      end
   end

   assign credit_err = credit_err_q;

endmodule
